panda_data_mem: RTL and testbench

Data-memory responder at the far end of the core's data port. It accepts the word address, write data and byte write-enables driven by the memory stage, and returns read data in the same cycle. It holds a byte-writable word RAM plus a small memory-mapped region with a 64-bit cycle timer, a timer compare/interrupt, and a simulation `tohost` mailbox. It sits beside the core in the top-level, wired directly to the data port.

---
 rtl/panda_pkg.sv | 36 +++
 rtl/panda_data_mem_if.sv | 10 +
 rtl/panda_dmem_timer.sv | 67 ++++++
 rtl/panda_data_mem.sv | 109 ++++++++++
 tb/tb_panda_data_mem.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/panda_pkg.sv
// Shared constants, types and helpers for the panda data memory.
package panda_pkg;

  // Default base of the 4 KiB memory-mapped register window.
  localparam logic [31:0] DMEM_MMIO_BASE = 32'h8000_0000;

  // Byte offsets of the registers inside the MMIO window.
  localparam logic [11:0] MMIO_MTIME_LO    = 12'h000;
  localparam logic [11:0] MMIO_MTIME_HI    = 12'h004;
  localparam logic [11:0] MMIO_MTIMECMP_LO = 12'h008;
  localparam logic [11:0] MMIO_MTIMECMP_HI = 12'h00C;
  localparam logic [11:0] MMIO_TOHOST      = 12'h010;

  // Target of the current access.
  typedef enum logic {
    DMEM_SEL_RAM  = 1'b0,
    DMEM_SEL_MMIO = 1'b1
  } dmem_sel_e;

  // Replace the bytes of old_word whose enable bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/panda_data_mem_if.sv
// Core data port: word address, store data, byte enables and read data.
interface panda_data_mem_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  we;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/panda_dmem_timer.sv
// Machine timer: free-running 64-bit mtime, byte-writable mtimecmp and a
// registered interrupt, plus the read mux for those four registers.
module panda_dmem_timer
  import panda_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [9:0]  word_off_i,
  input  logic        wr_en_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_timer_o
);

  logic [63:0] mtime_r;
  logic [63:0] mtimecmp_r;
  logic        irq_r;
  logic        cmp_lo_wr_s;
  logic        cmp_hi_wr_s;

  // Decode writes aimed at the two compare halves.
  always_comb begin
    cmp_lo_wr_s = 1'b0;
    cmp_hi_wr_s = 1'b0;
    if (wr_en_i) begin
      cmp_lo_wr_s = (word_off_i == MMIO_MTIMECMP_LO[11:2]);
      cmp_hi_wr_s = (word_off_i == MMIO_MTIMECMP_HI[11:2]);
    end else begin
      cmp_lo_wr_s = 1'b0;
      cmp_hi_wr_s = 1'b0;
    end
  end

  // Counter, compare register and interrupt; compare uses pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mtime_r    <= 64'h0;
      mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
      irq_r      <= 1'b0;
    end else begin
      mtime_r <= mtime_r + 64'd1;
      irq_r   <= (mtime_r >= mtimecmp_r);
      if (cmp_lo_wr_s) begin
        mtimecmp_r[31:0] <= merge_bytes(mtimecmp_r[31:0], wdata_i, be_i);
      end
      if (cmp_hi_wr_s) begin
        mtimecmp_r[63:32] <= merge_bytes(mtimecmp_r[63:32], wdata_i, be_i);
      end
    end
  end

  // Register read mux; anything not a timer register reads as zero.
  always_comb begin
    rdata_o = 32'h0;
    case (word_off_i)
      MMIO_MTIME_LO[11:2]:    rdata_o = mtime_r[31:0];
      MMIO_MTIME_HI[11:2]:    rdata_o = mtime_r[63:32];
      MMIO_MTIMECMP_LO[11:2]: rdata_o = mtimecmp_r[31:0];
      MMIO_MTIMECMP_HI[11:2]: rdata_o = mtimecmp_r[63:32];
      default:                rdata_o = 32'h0;
    endcase
  end

  assign irq_timer_o = irq_r;

endmodule

// File: rtl/panda_data_mem.sv
// Data-memory responder: byte-writable word RAM with asynchronous read.
// Optional feature macro PANDA_DMEM_MMIO_EN adds the MMIO window with the
// machine timer and the tohost mailbox; without it every address is RAM.
module panda_data_mem
  import panda_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = DMEM_MMIO_BASE
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  panda_data_mem_if.slave  dmem,
  output logic [31:0]      tohost_o,
  output logic             tohost_valid_o,
  output logic             irq_timer_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      mem_r [DEPTH_WORDS];
  logic [IDX_W-1:0] idx_s;
  logic [31:0]      ram_rdata_s;
  logic [31:0]      mmio_rdata_s;
  dmem_sel_e        sel_s;
  logic             unused_addr_s;

  assign idx_s         = dmem.addr[IDX_W+1:2];
  assign ram_rdata_s   = mem_r[idx_s];
  // Upper bits alias and the byte offset is ignored.
  assign unused_addr_s = ^{dmem.addr[31:IDX_W+2], dmem.addr[1:0]};

`ifdef PANDA_DMEM_MMIO_EN
  logic        mmio_wr_s;
  logic        tohost_wr_s;
  logic [31:0] tohost_r;
  logic        tohost_valid_r;

  // Route the access to RAM or to the MMIO window.
  always_comb begin
    sel_s = DMEM_SEL_RAM;
    if (dmem.addr[31:12] == MMIO_BASE[31:12]) begin
      sel_s = DMEM_SEL_MMIO;
    end else begin
      sel_s = DMEM_SEL_RAM;
    end
  end

  assign mmio_wr_s   = (sel_s == DMEM_SEL_MMIO) && (dmem.we != 4'b0000);
  assign tohost_wr_s = mmio_wr_s && ({dmem.addr[11:2], 2'b00} == MMIO_TOHOST);

  panda_dmem_timer u_timer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .word_off_i  (dmem.addr[11:2]),
    .wr_en_i     (mmio_wr_s),
    .be_i        (dmem.we),
    .wdata_i     (dmem.wdata),
    .rdata_o     (mmio_rdata_s),
    .irq_timer_o (irq_timer_o)
  );

  // Mailbox takes the whole word on any enabled write; valid pulses one cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tohost_r       <= 32'h0;
      tohost_valid_r <= 1'b0;
    end else begin
      tohost_valid_r <= tohost_wr_s;
      if (tohost_wr_s) begin
        tohost_r <= dmem.wdata;
      end
    end
  end

  assign tohost_o       = tohost_r;
  assign tohost_valid_o = tohost_valid_r;
`else
  logic unused_base_s;

  assign unused_base_s  = ^MMIO_BASE;
  assign sel_s          = DMEM_SEL_RAM;
  assign mmio_rdata_s   = 32'h0;
  assign tohost_o       = 32'h0;
  assign tohost_valid_o = 1'b0;
  assign irq_timer_o    = 1'b0;
`endif

  // RAM byte-lane writes; not reset so a store in the reset cycle still lands.
  always_ff @(posedge clk_i) begin
    if (sel_s == DMEM_SEL_RAM) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem.we[i]) begin
          mem_r[idx_s][8*i +: 8] <= dmem.wdata[8*i +: 8];
        end
      end
    end
  end

  // Zero-latency read data from the selected target.
  always_comb begin
    dmem.rdata = ram_rdata_s;
    case (sel_s)
      DMEM_SEL_RAM:  dmem.rdata = ram_rdata_s;
      DMEM_SEL_MMIO: dmem.rdata = mmio_rdata_s;
      default:       dmem.rdata = ram_rdata_s;
    endcase
  end

endmodule

// File: tb/tb_panda_data_mem.sv
// Self-checking bench for panda_data_mem with a behavioural reference model.
// Covers the MMIO features when PANDA_DMEM_MMIO_EN is defined, otherwise the
// plain-RAM build.
module tb_panda_data_mem;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tohost;
  logic        tohost_valid;
  logic        irq;

  panda_data_mem_if bus ();

  panda_data_mem #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .dmem           (bus),
    .tohost_o       (tohost),
    .tohost_valid_o (tohost_valid),
    .irq_timer_o    (irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] ram_m   [DEPTH];
  bit          known_m [DEPTH];
  logic [63:0] mtime_m  = 64'h0;
  logic [63:0] cmp_m    = 64'hFFFF_FFFF_FFFF_FFFF;
  logic        irq_m    = 1'b0;
  logic [31:0] tohost_m = 32'h0;
  logic        valid_m  = 1'b0;

  int checks   = 0;
  int failures = 0;

  function automatic bit is_mmio(input logic [31:0] a);
`ifdef PANDA_DMEM_MMIO_EN
    return (a[31:12] == BASE[31:12]);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [11:0] off;
    off = {a[11:2], 2'b00};
    if (is_mmio(a)) begin
      if (off == 12'h000)      return mtime_m[31:0];
      else if (off == 12'h004) return mtime_m[63:32];
      else if (off == 12'h008) return cmp_m[31:0];
      else if (off == 12'h00C) return cmp_m[63:32];
      else                     return 32'h0;
    end
    return ram_m[a[13:2]];
  endfunction

  function automatic bit exp_known(input logic [31:0] a);
    if (is_mmio(a)) return 1'b1;
    return known_m[a[13:2]];
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = we;
  endtask

  // One clock edge; the model applies the rules to the inputs held across it.
  task automatic step();
    logic [11:0] idx;
    logic [11:0] off;
    logic [63:0] mt_n;
    logic [63:0] cmp_n;
    logic        irq_n;
    logic [31:0] th_n;
    logic        v_n;
    @(posedge clk);
    idx = bus.addr[13:2];
    off = {bus.addr[11:2], 2'b00};
    if (!is_mmio(bus.addr)) begin
      for (int i = 0; i < 4; i++)
        if (bus.we[i]) ram_m[idx][8*i +: 8] = bus.wdata[8*i +: 8];
      if (bus.we == 4'hF) known_m[idx] = 1'b1;
    end
    if (!rst_n) begin
      mt_n = 64'h0; cmp_n = 64'hFFFF_FFFF_FFFF_FFFF; irq_n = 1'b0; th_n = 32'h0; v_n = 1'b0;
    end else begin
      mt_n = mtime_m + 64'd1; irq_n = (mtime_m >= cmp_m); cmp_n = cmp_m; th_n = tohost_m; v_n = 1'b0;
      if (is_mmio(bus.addr) && bus.we != 4'h0) begin
        for (int i = 0; i < 4; i++) begin
          if (off == 12'h008 && bus.we[i]) cmp_n[8*i +: 8]      = bus.wdata[8*i +: 8];
          if (off == 12'h00C && bus.we[i]) cmp_n[32 + 8*i +: 8] = bus.wdata[8*i +: 8];
        end
        if (off == 12'h010) begin th_n = bus.wdata; v_n = 1'b1; end
      end
    end
`ifdef PANDA_DMEM_MMIO_EN
    mtime_m = mt_n; cmp_m = cmp_n; irq_m = irq_n; tohost_m = th_n; valid_m = v_n;
`endif
    #1;
  endtask

  task automatic test_reset();
    drive(32'h0, 32'h0, 4'h0);
    rst_n = 1'b0;
    step(); step();
    checks++; if (tohost !== 32'h0) begin failures++; $display("FAIL reset_tohost got=%h exp=%h", tohost, 32'h0); end
    checks++; if (tohost_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", tohost_valid); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
`ifdef PANDA_DMEM_MMIO_EN
    drive(BASE + 32'h8, 32'h0, 4'h0); #1;
    checks++; if (bus.rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_cmp_lo got=%h exp=ffffffff", bus.rdata); end
    drive(BASE, 32'h0, 4'h0);
`endif
    rst_n = 1'b1;
  endtask

`ifdef PANDA_DMEM_MMIO_EN
  task automatic test_timer();
    bit rose;
    for (int i = 0; i < 10; i++) step();
    drive(BASE, 32'h0, 4'h0); #1;
    checks++; if (bus.rdata !== 32'd10) begin failures++; $display("FAIL mtime_after_10 got=%0d exp=10", bus.rdata); end
    drive(BASE + 32'hC, 32'h0, 4'hF); step();
    drive(BASE + 32'h8, 32'd20, 4'hF); step();
    drive(BASE, 32'h0, 4'h0);
    rose = 1'b0;
    for (int i = 0; i < 40 && !rose; i++) begin
      step();
      checks++; if (irq !== irq_m) begin failures++; $display("FAIL irq_track got=%b exp=%b", irq, irq_m); end
      if (irq === 1'b1) begin
        rose = 1'b1;
        checks++; if (bus.rdata !== 32'd21) begin failures++; $display("FAIL irq_rise_time mtime=%0d exp=21", bus.rdata); end
      end
    end
    checks++; if (!rose) begin failures++; $display("FAIL irq_timeout got=0 exp=1"); end
  endtask

  task automatic test_mailbox();
    drive(BASE + 32'h10, 32'h1, 4'b0001); step();
    checks++; if (tohost !== 32'h1) begin failures++; $display("FAIL tohost_val got=%h exp=00000001", tohost); end
    checks++; if (tohost_valid !== 1'b1) begin failures++; $display("FAIL tohost_pulse got=%b exp=1", tohost_valid); end
    drive(BASE + 32'h10, 32'h0, 4'h0); #1;
    checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL tohost_read got=%h exp=0", bus.rdata); end
    step();
    checks++; if (tohost_valid !== 1'b0) begin failures++; $display("FAIL tohost_pulse_end got=%b exp=0", tohost_valid); end
    drive(BASE + 32'h20, 32'hABCD_1234, 4'hF); step();
    drive(BASE + 32'h20, 32'h0, 4'h0); #1;
    checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=0", bus.rdata); end
    checks++; if (tohost !== 32'h1 || tohost_valid !== 1'b0) begin failures++; $display("FAIL unmapped_write tohost=%h valid=%b exp=00000001/0", tohost, tohost_valid); end
    drive(BASE + 32'h10, 32'hCAFE_BA02, 4'b0001); step();
    checks++; if (tohost !== 32'hCAFE_BA02) begin failures++; $display("FAIL tohost_full_word got=%h exp=cafeba02", tohost); end
    drive(32'h0, 32'h0, 4'h0); step();
  endtask

  task automatic test_wrap();
    force dut.u_timer.mtime_r = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut.u_timer.mtime_r;
    mtime_m = 64'hFFFF_FFFF_FFFF_FFFE;
    drive(BASE, 32'h0, 4'h0);
    step(); step();
    checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL wrap_lo got=%h exp=0", bus.rdata); end
    drive(BASE + 32'h4, 32'h0, 4'h0); #1;
    checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL wrap_hi got=%h exp=0", bus.rdata); end
  endtask
`else
  task automatic test_no_mmio();
    drive(BASE, 32'h1234_5678, 4'hF); step();
    drive(BASE, 32'h0, 4'h0); #1;
    checks++; if (bus.rdata !== 32'h1234_5678) begin failures++; $display("FAIL base_is_ram got=%h exp=12345678", bus.rdata); end
    drive(BASE + 32'h10, 32'h1, 4'hF); step();
    checks++; if (tohost !== 32'h0 || tohost_valid !== 1'b0 || irq !== 1'b0) begin failures++; $display("FAIL outputs_tied tohost=%h valid=%b irq=%b exp=0", tohost, tohost_valid, irq); end
    drive(32'h0, 32'h0, 4'h0); #1;
    checks++; if (bus.rdata !== 32'h1234_5678) begin failures++; $display("FAIL base_alias0 got=%h exp=12345678", bus.rdata); end
  endtask
`endif

  task automatic test_ram_lanes();
    drive(32'h100, 32'hDEAD_BEEF, 4'hF); step();
    drive(32'h100, 32'h0000_00AA, 4'b0001); step();
    drive(32'h100, 32'h0, 4'h0); #1;
    checks++; if (bus.rdata !== 32'hDEAD_BEAA) begin failures++; $display("FAIL ram_lane got=%h exp=deadbeaa", bus.rdata); end
    drive(32'h100 + 32'(4 * DEPTH), 32'h0, 4'h0); #1;
    checks++; if (bus.rdata !== 32'hDEAD_BEAA) begin failures++; $display("FAIL ram_alias got=%h exp=deadbeaa", bus.rdata); end
    drive(32'h102, 32'h5500_0000, 4'b1000); step();
    drive(32'h101, 32'h0, 4'h0); #1;
    checks++; if (bus.rdata !== 32'h55AD_BEAA) begin failures++; $display("FAIL ram_lane3 got=%h exp=55adbeaa", bus.rdata); end
  endtask

  task automatic test_same_cycle();
    drive(32'h40, 32'h0, 4'hF); step();
    drive(32'h40, 32'h1111_1111, 4'hF); #1;
    checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL same_cycle_old got=%h exp=0", bus.rdata); end
    step();
    drive(32'h40, 32'h0, 4'h0); #1;
    checks++; if (bus.rdata !== 32'h1111_1111) begin failures++; $display("FAIL same_cycle_new got=%h exp=11111111", bus.rdata); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  we;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 1) == 0)
        a = 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 7) << 14) | 32'($urandom_range(0, 3));
      else
        a = BASE + 32'($urandom_range(0, 8) << 2);
      d  = $urandom;
      we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      drive(a, d, we); #1;
      if (exp_known(a)) begin
        checks++; if (bus.rdata !== exp_read(a)) begin failures++; $display("FAIL rand_read addr=%h got=%h exp=%h", a, bus.rdata, exp_read(a)); end
      end
      step();
      checks++;
      if (irq !== irq_m || tohost !== tohost_m || tohost_valid !== valid_m) begin
        failures++;
        $display("FAIL rand_outputs irq=%b/%b tohost=%h/%h valid=%b/%b (got/exp)", irq, irq_m, tohost, tohost_m, tohost_valid, valid_m);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(BASE + 32'hC, 32'h0, 4'hF); step();
    drive(BASE + 32'h8, 32'h30, 4'hF); step();
    drive(32'h200, 32'h5A5A_5A5A, 4'hF); step();
    drive(32'h0, 32'h0, 4'h0); step(); step();
    rst_n = 1'b0;
    drive(32'h204, 32'h7777_7777, 4'hF); step();
    drive(BASE + 32'h8, 32'h5, 4'hF); step();
    checks++; if (irq !== 1'b0 || tohost !== 32'h0 || tohost_valid !== 1'b0) begin failures++; $display("FAIL midreset_outs irq=%b tohost=%h valid=%b exp=0", irq, tohost, tohost_valid); end
    drive(32'h200, 32'h0, 4'h0); #1;
    checks++; if (bus.rdata !== 32'h5A5A_5A5A) begin failures++; $display("FAIL midreset_ram_keep got=%h exp=5a5a5a5a", bus.rdata); end
    drive(32'h204, 32'h0, 4'h0); #1;
    checks++; if (bus.rdata !== 32'h7777_7777) begin failures++; $display("FAIL midreset_ram_write got=%h exp=77777777", bus.rdata); end
`ifdef PANDA_DMEM_MMIO_EN
    drive(BASE + 32'h8, 32'h0, 4'h0); #1;
    checks++; if (bus.rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL midreset_cmp_lo got=%h exp=ffffffff", bus.rdata); end
    drive(BASE + 32'hC, 32'h0, 4'h0); #1;
    checks++; if (bus.rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL midreset_cmp_hi got=%h exp=ffffffff", bus.rdata); end
    drive(BASE, 32'h0, 4'h0);
    rst_n = 1'b1; #1;
    checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL midreset_mtime0 got=%h exp=0", bus.rdata); end
    step();
    checks++; if (bus.rdata !== 32'h1) begin failures++; $display("FAIL midreset_mtime1 got=%h exp=1", bus.rdata); end
`else
    rst_n = 1'b1;
    step();
`endif
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) known_m[i] = 1'b0;
    test_reset();
`ifdef PANDA_DMEM_MMIO_EN
    test_timer();
`endif
    test_ram_lanes();
    test_same_cycle();
`ifdef PANDA_DMEM_MMIO_EN
    test_mailbox();
    test_wrap();
`else
    test_no_mmio();
`endif
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
